fire_scheduler: RTL and testbench

//   Drives the ena vector of the synchronous circuit model. Each DFF-modelled input/gate is one ena bit.

---
 rtl/fire_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fire_scheduler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fire_scheduler.sv
// Firing scheduler for the synchronous circuit model: grants one excited element per
// two-cycle firing step (round-robin or LFSR-random) and flags deadlock when nothing is excited.
module fire_scheduler #(
    parameter int N           = 8,
    parameter int LFSR_W      = 16,
    parameter int STALL_LIMIT = 4,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           excited,
    input  logic                   mode,
    input  logic [LFSR_W-1:0]      seed,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   step_mode,
    input  logic                   step,
    output logic [N-1:0]           ena,
    output logic [$clog2(N)-1:0]   fire_idx,
    output logic                   fire_valid,
    output logic                   deadlock,
    output logic [CNT_W-1:0]       fire_count,
    output logic [1:0]             state
);

    localparam int IDX_W   = $clog2(N);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(16'hB400);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PICK     = 2'd1,
        FIRE     = 2'd2,
        DEADLOCK = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [LFSR_W-1:0]    lfsr;
    logic [LFSR_W-1:0]    lfsr_step;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     pick_idx;
    logic [STALL_W-1:0]   stall;
    logic                 step_armed;
    logic                 pick_ok;
    logic                 found;
    logic                 stall_expired;
    int                   sel_base;
    int                   sel_cand;

    assign state         = state_q;
    assign pick_ok       = !step_mode || step_armed;
    assign stall_expired = (stall == STALL_W'(STALL_LIMIT - 1));
    assign lfsr_step     = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

    // Rotating priority search: round-robin starts just past the last grant,
    // random mode starts at an LFSR-chosen base; both wrap modulo N.
    always_comb begin
        found    = 1'b0;
        pick_idx = '0;
        sel_cand = 0;
        if (mode)
            sel_base = int'(lfsr[IDX_W-1:0]) % N;
        else
            sel_base = (int'(rr_ptr) + 1) % N;
        for (int k = 0; k < N; k++) begin
            sel_cand = (sel_base + k) % N;
            if (!found && excited[IDX_W'(sel_cand)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(sel_cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = PICK;
            end
            PICK: begin
                if (halt_req)
                    state_d = IDLE;
                else if (pick_ok && found)
                    state_d = FIRE;
                else if (pick_ok && stall_expired)
                    state_d = DEADLOCK;
            end
            FIRE: begin
                state_d = halt_req ? IDLE : PICK;
            end
            DEADLOCK: begin
                if (start)
                    state_d = PICK;
                else if (halt_req)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // ena and fire_valid are registered so they are high only for the FIRE
    // cycle, and drop asynchronously if reset hits mid-fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ena        <= '0;
            fire_valid <= 1'b0;
            fire_idx   <= '0;
            deadlock   <= 1'b0;
            fire_count <= '0;
            lfsr       <= LFSR_W'(1);
            rr_ptr     <= IDX_W'(N - 1);
            grant      <= '0;
            stall      <= '0;
            step_armed <= 1'b0;
        end else begin
            ena        <= '0;
            fire_valid <= 1'b0;
            if (step && state_q != FIRE)
                step_armed <= 1'b1;
            case (state_q)
                IDLE, DEADLOCK: begin
                    if (start) begin
                        lfsr     <= (seed == '0) ? LFSR_W'(1) : seed;
                        stall    <= '0;
                        deadlock <= 1'b0;
                    end
                end
                PICK: begin
                    lfsr <= lfsr_step;
                    if (state_d == FIRE) begin
                        grant      <= pick_idx;
                        stall      <= '0;
                        step_armed <= 1'b0;
                        ena        <= N'(1) << pick_idx;
                        fire_valid <= 1'b1;
                    end else if (!halt_req && pick_ok) begin
                        stall <= stall + STALL_W'(1);
                    end
                    if (state_d == DEADLOCK)
                        deadlock <= 1'b1;
                end
                FIRE: begin
                    rr_ptr   <= grant;
                    fire_idx <= grant;
                    if (fire_count != {CNT_W{1'b1}})
                        fire_count <= fire_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fire_scheduler.sv
// Directed bench for fire_scheduler: round-robin table, deadlock, LFSR-random,
// step mode, reset/halt during FIRE and counter saturation on a narrow-counter copy.
module tb_fire_scheduler;

    logic        clk;
    logic        reset;
    logic [7:0]  excited;
    logic        mode;
    logic [15:0] seed;
    logic        start;
    logic        halt_req;
    logic        step_mode;
    logic        step;

    logic [7:0]  ena;
    logic [2:0]  fire_idx;
    logic        fire_valid;
    logic        deadlock;
    logic [31:0] fire_count;
    logic [1:0]  state;

    logic [7:0]  ena_s;
    logic [2:0]  fire_idx_s;
    logic        fire_valid_s;
    logic        deadlock_s;
    logic [3:0]  fire_count_s;
    logic [1:0]  state_s;

    int n_compared;
    int n_mismatched;

    typedef struct {
        logic [7:0] exc;
        logic [7:0] exp_ena;
        logic [2:0] exp_idx;
    } rr_vec_t;

    rr_vec_t rr_tab[14];

    fire_scheduler #(.N(8), .LFSR_W(16), .STALL_LIMIT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .excited(excited), .mode(mode), .seed(seed),
        .start(start), .halt_req(halt_req), .step_mode(step_mode), .step(step),
        .ena(ena), .fire_idx(fire_idx), .fire_valid(fire_valid), .deadlock(deadlock),
        .fire_count(fire_count), .state(state)
    );

    fire_scheduler #(.N(8), .LFSR_W(16), .STALL_LIMIT(4), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .excited(excited), .mode(mode), .seed(seed),
        .start(start), .halt_req(halt_req), .step_mode(step_mode), .step(step),
        .ena(ena_s), .fire_idx(fire_idx_s), .fire_valid(fire_valid_s), .deadlock(deadlock_s),
        .fire_count(fire_count_s), .state(state_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] exc, input logic st);
        excited = exc;
        start   = st;
        tick();
        start   = 1'b0;
    endtask

    task automatic do_reset();
        excited   = '0;
        mode      = 1'b0;
        seed      = '0;
        start     = 1'b0;
        halt_req  = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int model_pick(input logic [7:0] exc, input int base);
        for (int k = 0; k < 8; k++)
            if (exc[(base + k) % 8])
                return (base + k) % 8;
        return 0;
    endfunction

    task automatic run_random(input logic [15:0] seed_val, input int n_fires);
        logic [15:0] model;
        logic [7:0]  exp_ena;
        int          g;
        do_reset();
        mode = 1'b1;
        seed = seed_val;
        apply_stimulus(8'h00, 1'b1);
        model = (seed_val == 16'h0) ? 16'h1 : seed_val;
        for (int i = 0; i < n_fires; i++) begin
            excited = 8'($urandom_range(1, 255));
            g       = model_pick(excited, int'(model[2:0]));
            model   = lfsr_next(model);
            exp_ena = 8'h01 << g;
            tick();
            check_output("random_grant", {24'h0, ena}, {24'h0, exp_ena});
            tick();
        end
        mode = 1'b0;
    endtask

    initial begin
        int fires;
        n_compared   = 0;
        n_mismatched = 0;

        rr_tab[0]  = '{8'hA4, 8'h04, 3'd2};
        rr_tab[1]  = '{8'hA4, 8'h20, 3'd5};
        rr_tab[2]  = '{8'hA4, 8'h80, 3'd7};
        rr_tab[3]  = '{8'hA4, 8'h04, 3'd2};
        rr_tab[4]  = '{8'h01, 8'h01, 3'd0};
        rr_tab[5]  = '{8'h01, 8'h01, 3'd0};
        rr_tab[6]  = '{8'hFF, 8'h02, 3'd1};
        rr_tab[7]  = '{8'h81, 8'h80, 3'd7};
        rr_tab[8]  = '{8'h81, 8'h01, 3'd0};
        rr_tab[9]  = '{8'h18, 8'h08, 3'd3};
        rr_tab[10] = '{8'h10, 8'h10, 3'd4};
        rr_tab[11] = '{8'h0C, 8'h04, 3'd2};
        rr_tab[12] = '{8'h40, 8'h40, 3'd6};
        rr_tab[13] = '{8'h7F, 8'h01, 3'd0};

        do_reset();
        check_output("reset_state", {30'h0, state}, 32'd0);
        check_output("reset_ena", {24'h0, ena}, 32'h0);
        check_output("reset_fire_valid", {31'h0, fire_valid}, 32'h0);
        check_output("reset_fire_idx", {29'h0, fire_idx}, 32'h0);
        check_output("reset_deadlock", {31'h0, deadlock}, 32'h0);
        check_output("reset_fire_count", fire_count, 32'h0);

        // Round-robin sequence, one fire every second cycle
        apply_stimulus(8'hA4, 1'b1);
        for (int i = 0; i < 14; i++) begin
            excited = rr_tab[i].exc;
            tick();
            check_output("rr_fire_ena", {24'h0, ena}, {24'h0, rr_tab[i].exp_ena});
            check_output("rr_fire_valid", {31'h0, fire_valid}, 32'h1);
            check_output("rr_fire_state", {30'h0, state}, 32'd2);
            tick();
            check_output("rr_gap_ena", {24'h0, ena}, 32'h0);
            check_output("rr_gap_valid", {31'h0, fire_valid}, 32'h0);
            check_output("rr_fire_idx", {29'h0, fire_idx}, {29'h0, rr_tab[i].exp_idx});
            check_output("rr_fire_count", fire_count, 32'(i + 1));
        end
        excited = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            tick();
            tick();
        end
        check_output("count_20", fire_count, 32'd20);
        check_output("small_count_sat", {28'h0, fire_count_s}, 32'hF);

        // Deadlock after four empty PICK cycles, then recovery
        do_reset();
        apply_stimulus(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        check_output("stall_still_pick", {30'h0, state}, 32'd1);
        tick();
        check_output("deadlock_state", {30'h0, state}, 32'd3);
        check_output("deadlock_flag", {31'h0, deadlock}, 32'h1);
        check_output("deadlock_ena", {24'h0, ena}, 32'h0);
        apply_stimulus(8'h01, 1'b1);
        check_output("restart_state", {30'h0, state}, 32'd1);
        check_output("restart_deadlock_clr", {31'h0, deadlock}, 32'h0);
        tick();
        check_output("restart_ena", {24'h0, ena}, 32'h01);
        excited = 8'h00;
        for (int i = 0; i < 5; i++) tick();
        check_output("deadlock_again", {30'h0, state}, 32'd3);
        halt_req = 1'b1;
        tick();
        check_output("halt_deadlock_idle", {30'h0, state}, 32'd0);
        check_output("halt_deadlock_sticky", {31'h0, deadlock}, 32'h1);
        start = 1'b1;
        tick();
        start    = 1'b0;
        halt_req = 1'b0;
        check_output("start_beats_halt", {30'h0, state}, 32'd1);

        run_random(16'h0000, 100);
        run_random(16'hACE1, 100);

        // Step mode: no fires without a step, one fire per pulse burst
        do_reset();
        step_mode = 1'b1;
        apply_stimulus(8'hFF, 1'b1);
        fires = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ena != 8'h00) fires++;
        end
        check_output("step_idle_fires", 32'(fires), 32'd0);
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            step = (c < 1);
            tick();
            if (fire_valid) fires++;
        end
        check_output("step_single_pulse", 32'(fires), 32'd1);
        fires = 0;
        for (int c = 0; c < 8; c++) begin
            step = (c < 3);
            tick();
            if (fire_valid) fires++;
        end
        step = 1'b0;
        check_output("step_triple_pulse", 32'(fires), 32'd1);
        check_output("step_count", fire_count, 32'd2);

        // Asynchronous reset in the middle of a FIRE cycle
        do_reset();
        apply_stimulus(8'hFF, 1'b1);
        tick();
        check_output("prereset_ena", {24'h0, ena}, 32'h01);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_ena", {24'h0, ena}, 32'h0);
        check_output("async_reset_state", {30'h0, state}, 32'd0);
        check_output("async_reset_count", fire_count, 32'h0);
        reset = 1'b0;

        // halt_req during FIRE lets the fire complete, then goes idle
        apply_stimulus(8'hFF, 1'b1);
        tick();
        check_output("halt_fire_valid", {31'h0, fire_valid}, 32'h1);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check_output("halt_fire_state", {30'h0, state}, 32'd0);
        check_output("halt_fire_count", fire_count, 32'd1);
        tick();
        check_output("halt_stays_idle", {30'h0, state}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
